// File: rtl/ss_read_data.sv
// BRAM read stage: streams words at addresses si..ei (inclusive) over valid/ready.
// A credit-limited FIFO of depth RD_LAT+1 absorbs read latency so stalls never lose words.
module ss_read_data #(
   parameter int SIZE_ADDR = 6,
   parameter int SIZE_DATA = 8,
   parameter int RD_LAT    = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start_read_data,
   input  logic [SIZE_ADDR-1:0] i_si_ram,
   input  logic [SIZE_ADDR-1:0] i_ei_ram,
   output logic                 o_re_ram,
   output logic [SIZE_ADDR-1:0] o_addr_ram,
   input  logic [SIZE_DATA-1:0] i_data_ram,
   output logic                 o_valid,
   output logic [SIZE_DATA-1:0] o_data,
   input  logic                 i_ready,
   output logic                 o_busy,
   output logic                 o_done_read_data
);

   localparam int DEPTH = RD_LAT + 1;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [CW:0]        DEPTH_W  = (CW+1)'(DEPTH);
   localparam logic [PW-1:0]      PTR_LAST = PW'(DEPTH - 1);
   localparam logic [SIZE_ADDR:0] CNT_ONE  = (SIZE_ADDR+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic                 start_prev_q;
   logic [SIZE_ADDR-1:0] si_q, si_d, ei_q, ei_d, addr_q, addr_d;
   logic [SIZE_ADDR:0]   xfer_cnt_q, xfer_cnt_d, n_words;
   logic [RD_LAT-1:0]    infl_q, infl_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]        count_q, count_d, infl_cnt;
   logic [CW:0]          occ_after;
   logic [SIZE_DATA-1:0] fifo_mem [DEPTH];
   logic                 start_edge, empty_range, issue, fifo_wr, fifo_rd, has_credit;

   assign start_edge  = i_start_read_data & ~start_prev_q;
   assign empty_range = si_q > ei_q;
   assign n_words     = {1'b0, ei_q} - {1'b0, si_q} + CNT_ONE;
   assign fifo_wr     = infl_q[RD_LAT-1];
   assign fifo_rd     = o_valid & i_ready;

   // In-flight read tracker: bit 0 marks this cycle's issue, the top bit marks returning data.
   assign infl_d[0] = issue;
   for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_infl
      assign infl_d[gi] = infl_q[gi-1];
   end

   always_comb begin
      infl_cnt = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         infl_cnt = infl_cnt + CW'(infl_q[i]);
      end
   end

   // A pop this cycle frees a slot before any read issued now can return, so count it as credit.
   assign occ_after  = {1'b0, count_q} + {1'b0, infl_cnt} - {{CW{1'b0}}, fifo_rd};
   assign has_credit = occ_after < DEPTH_W;

   always_comb begin
      state_d    = state_q;
      si_d       = si_q;
      ei_d       = ei_q;
      addr_d     = addr_q;
      issue      = 1'b0;
      xfer_cnt_d = xfer_cnt_q + (SIZE_ADDR+1)'(fifo_rd);
      case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               si_d       = i_si_ram;
               ei_d       = i_ei_ram;
               addr_d     = i_si_ram;
               xfer_cnt_d = '0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (empty_range) begin
               state_d = S_DRAIN;
            end else if (has_credit) begin
               issue = 1'b1;
               if (addr_q == ei_q) begin
                  state_d = S_DRAIN;
               end else begin
                  addr_d = addr_q + SIZE_ADDR'(1);
               end
            end
         end
         S_DRAIN: begin
            if (empty_range || xfer_cnt_d == n_words) begin
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(fifo_wr) - CW'(fifo_rd);
      if (fifo_wr) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (fifo_rd) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         start_prev_q <= 1'b0;
         si_q         <= '0;
         ei_q         <= '0;
         addr_q       <= '0;
         xfer_cnt_q   <= '0;
         infl_q       <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= i_start_read_data;
         si_q         <= si_d;
         ei_q         <= ei_d;
         addr_q       <= addr_d;
         xfer_cnt_q   <= xfer_cnt_d;
         infl_q       <= infl_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr_q] <= i_data_ram;
      end
      if (!i_rst) begin
         assert (!(fifo_wr && !fifo_rd && count_q == CW'(DEPTH)));
      end
   end

   assign o_re_ram         = issue;
   assign o_addr_ram       = addr_q;
   assign o_valid          = count_q != '0;
   assign o_data           = o_valid ? fifo_mem[rd_ptr_q] : '0;
   assign o_busy           = state_q != S_IDLE;
   assign o_done_read_data = state_q == S_DONE;

endmodule

// File: tb/tb_ss_read_data.sv
// Scoreboard bench for ss_read_data: expected words queued at start, popped on each transfer.
module tb_ss_read_data;

   logic       clk = 1'b0;
   logic       rst, start, re, valid, ready, busy, done;
   logic [5:0] si, ei, addr;
   logic [7:0] data_ram, data;
   logic [7:0] bram [64];
   logic [7:0] exp_q [$];
   logic [7:0] mon_exp;
   int         vectors = 0, miscompares = 0;
   int         reads, xfers, exp_addr;
   bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   ss_read_data #(.SIZE_ADDR(6), .SIZE_DATA(8), .RD_LAT(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_start_read_data(start),
      .i_si_ram(si), .i_ei_ram(ei), .o_re_ram(re), .o_addr_ram(addr),
      .i_data_ram(data_ram), .o_valid(valid), .o_data(data), .i_ready(ready),
      .o_busy(busy), .o_done_read_data(done)
   );

   // BRAM model with one cycle read latency
   initial data_ram = 8'h00;
   always @(posedge clk) if (re) data_ram <= bram[addr];

   always @(negedge clk) begin
      if (!rst) begin
         if (valid && ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL stream_extra: got %02h, expected no word", data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (data !== mon_exp) begin
                  miscompares++;
                  $display("FAIL stream_data: got %02h, expected %02h", data, mon_exp);
               end else
                  $display("word %02h accepted", data);
            end
            xfers++;
         end
         if (re) begin
            vectors++;
            if (addr !== exp_addr[5:0] || exp_addr > 63) begin
               miscompares++;
               $display("FAIL read_addr: got %0d, expected %0d", addr, exp_addr);
            end
            exp_addr++;
            reads++;
         end
         if (busy) begin
            vectors++;
            if (reads - xfers > 2) begin
               miscompares++;
               $display("FAIL credit: outstanding %0d, expected <= 2", reads - xfers);
            end
         end
      end
   end

   task automatic do_run(input logic [5:0] s, input logic [5:0] e, input int mode,
                         input bit retrigger, output int first_v, output int last_x,
                         output int done_k, output int done_cnt, output logic busy_fall);
      first_v = -1; last_x = -1; done_k = -1; done_cnt = 0; busy_fall = 1'bx;
      reads = 0; xfers = 0; exp_addr = int'(s);
      if (s <= e) for (int a = int'(s); a <= int'(e); a++) exp_q.push_back(bram[a]);
      si = s; ei = e; start = 1'b1; ready = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 600; k++) begin
         #1;
         ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 6] : 1'($urandom_range(0, 1));
         if (!retrigger && k == 1) start = 1'b0;
         if (retrigger && k == 3) start = 1'b0;
         if (retrigger && k == 4) start = 1'b1;
         @(negedge clk);
         if (valid && ready) begin
            if (first_v < 0) first_v = k;
            last_x = k;
         end
         if (done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (done_k >= 0 && k == done_k + 1) busy_fall = busy;
         if (done_k >= 0 && k >= done_k + (retrigger ? 12 : 3)) break;
         @(posedge clk);
      end
      @(posedge clk);
      #1;
      $display("run si=%0d ei=%0d mode=%0d: reads=%0d first_v=%0d last_x=%0d done_k=%0d",
               s, e, mode, reads, first_v, last_x, done_k);
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if ({re, valid, busy, done} !== 4'b0 || data !== 8'h00 || addr !== 6'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: re=%b valid=%b busy=%b done=%b data=%02h addr=%0d, expected all 0",
                  re, valid, busy, done, data, addr);
      end
      @(posedge clk); #1; rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: busy=%b valid=%b, expected 0 0", busy, valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int fv, lx, dk, dc; logic bf;
      do_run(6'd3, 6'd7, 0, 1'b0, fv, lx, dk, dc, bf);
      vectors++; if (fv !== 2) begin miscompares++; $display("FAIL basic_first_valid: got %0d, expected 2", fv); end
      vectors++; if (lx !== 6) begin miscompares++; $display("FAIL basic_last_xfer: got %0d, expected 6", lx); end
      vectors++; if (dk !== 7) begin miscompares++; $display("FAIL basic_done_cycle: got %0d, expected 7", dk); end
      vectors++; if (dc !== 1) begin miscompares++; $display("FAIL basic_done_count: got %0d, expected 1", dc); end
      vectors++; if (bf !== 1'b0) begin miscompares++; $display("FAIL basic_busy_fall: got %b, expected 0", bf); end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL basic_words_left: got %0d, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_ready_toggle();
      int fv, lx, dk, dc; logic bf;
      do_run(6'd3, 6'd7, 1, 1'b0, fv, lx, dk, dc, bf);
      vectors++; if (reads !== 5) begin miscompares++; $display("FAIL toggle_reads: got %0d, expected 5", reads); end
      vectors++; if (dk !== lx + 1) begin miscompares++; $display("FAIL toggle_done_cycle: got %0d, expected %0d", dk, lx + 1); end
      vectors++; if (dc !== 1) begin miscompares++; $display("FAIL toggle_done_count: got %0d, expected 1", dc); end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL toggle_words_left: got %0d, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_top_of_space();
      int fv, lx, dk, dc; logic bf;
      do_run(6'd63, 6'd63, 0, 1'b0, fv, lx, dk, dc, bf);
      vectors++; if (reads !== 1) begin miscompares++; $display("FAIL top1_reads: got %0d, expected 1", reads); end
      vectors++; if (dk !== 3) begin miscompares++; $display("FAIL top1_done_cycle: got %0d, expected 3", dk); end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL top1_words_left: got %0d, expected 0", exp_q.size()); exp_q.delete(); end
      do_run(6'd0, 6'd63, 0, 1'b0, fv, lx, dk, dc, bf);
      vectors++; if (reads !== 64) begin miscompares++; $display("FAIL full_reads: got %0d, expected 64", reads); end
      vectors++; if (lx !== 65) begin miscompares++; $display("FAIL full_last_xfer: got %0d, expected 65", lx); end
      vectors++; if (dk !== 66 || dc !== 1) begin miscompares++; $display("FAIL full_done: got cycle %0d count %0d, expected 66 1", dk, dc); end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL full_words_left: got %0d, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_empty_range();
      int fv, lx, dk, dc; logic bf;
      do_run(6'd9, 6'd4, 0, 1'b0, fv, lx, dk, dc, bf);
      vectors++; if (reads !== 0) begin miscompares++; $display("FAIL empty_reads: got %0d, expected 0", reads); end
      vectors++; if (fv !== -1) begin miscompares++; $display("FAIL empty_valid: got cycle %0d, expected none", fv); end
      vectors++; if (dk !== 2 || dc !== 1) begin miscompares++; $display("FAIL empty_done: got cycle %0d count %0d, expected 2 1", dk, dc); end
   endtask

   task automatic test_retrigger();
      int fv, lx, dk, dc; logic bf;
      do_run(6'd3, 6'd7, 0, 1'b1, fv, lx, dk, dc, bf);
      vectors++; if (reads !== 5) begin miscompares++; $display("FAIL retrig_reads: got %0d, expected 5", reads); end
      vectors++; if (dc !== 1) begin miscompares++; $display("FAIL retrig_done_count: got %0d, expected 1", dc); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL retrig_held_start: busy=%b, expected 0", busy); end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL retrig_words_left: got %0d, expected 0", exp_q.size()); exp_q.delete(); end
      start = 1'b0;
      @(posedge clk); #1;
      do_run(6'd20, 6'd25, 2, 1'b0, fv, lx, dk, dc, bf);
      vectors++; if (reads !== 6 || dc !== 1) begin miscompares++; $display("FAIL rerun: got reads %0d done %0d, expected 6 1", reads, dc); end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rerun_words_left: got %0d, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_mid_reset();
      int fv, lx, dk, dc, bad; logic bf;
      reads = 0; xfers = 0; exp_addr = 3; bad = 0;
      for (int a = 3; a <= 7; a++) exp_q.push_back(bram[a]);
      si = 6'd3; ei = 6'd7; ready = 1'b1; start = 1'b1;
      for (int k = 0; k < 20 && xfers < 2; k++) @(negedge clk);
      #2; rst = 1'b1; start = 1'b0;
      #1;
      vectors++;
      if ({re, valid, busy, done} !== 4'b0 || data !== 8'h00 || addr !== 6'd0) begin
         miscompares++;
         $display("FAIL midreset_outputs: re=%b valid=%b busy=%b done=%b data=%02h addr=%0d, expected all 0",
                  re, valid, busy, done, data, addr);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (valid || done || busy) bad++;
      end
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL midreset_quiet: got %0d active cycles, expected 0", bad); end
      @(posedge clk); #1;
      do_run(6'd3, 6'd7, 0, 1'b0, fv, lx, dk, dc, bf);
      vectors++; if (fv !== 2 || dk !== 7 || reads !== 5) begin miscompares++; $display("FAIL midreset_rerun: got first %0d done %0d reads %0d, expected 2 7 5", fv, dk, reads); end
      vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL midreset_words_left: got %0d, expected 0", exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) bram[i] = 8'(i + 16);
      rst = 1'b1; start = 1'b0; ready = 1'b0; si = '0; ei = '0;
      reads = 0; xfers = 0; exp_addr = 0;
      test_reset();
      test_basic();
      test_ready_toggle();
      test_top_of_space();
      test_empty_range();
      test_retrigger();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
